du_ex_skid_reg_way0: RTL and testbench

//  Way0 decode->execute pipeline register ("DU Register"), two-entry skid buffer.

---
 rtl/b8_pkg.sv | 35 +++
 rtl/skid_buffer.sv | 84 ++++++++
 rtl/du_ex_skid_reg_way0.sv | 93 +++++++++
 tb/tb_du_ex_skid_reg_way0.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/b8_pkg.sv
// Shared definitions for the way0 decode->execute register: payload bundle,
// widths, skid-buffer state encoding and a few RV64 opcode constants.
package b8_pkg;

  localparam int XLEN    = 64;
  localparam int IADDR_W = 32;
  localparam int PID_W   = 2;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    SB_EMPTY = 2'b00,
    SB_ONE   = 2'b01,
    SB_FULL  = 2'b11
  } sb_state_e;

  typedef struct packed {
    logic [4:0]         rdAddr;
    logic               rdWriteEnable;
    logic [IADDR_W-1:0] instAddr;
    logic [XLEN-1:0]    rs1ReadData;
    logic [XLEN-1:0]    rs2ReadData;
    logic [XLEN-1:0]    imm;
    logic [6:0]         opCode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [5:0]         shamt;
    logic [PID_W-1:0]   pID;
  } du_bundle_t;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry skid buffer with registered ready: main entry drives the output,
// skid entry absorbs the one bundle that arrives while the consumer stalls.
module skid_buffer
  import b8_pkg::*;
#(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o,
  output logic mainValid_o,
  output logic skidValid_o
);

  sb_state_e stateQ, stateD;
  logic      readyQ, readyD;
  T          mainQ, mainD;
  T          skidQ, skidD;
  logic      accept, deliver;

  assign accept  = valid_i & readyQ;
  assign deliver = (stateQ != SB_EMPTY) & ready_i;

  always_comb begin
    stateD = stateQ;
    mainD  = mainQ;
    skidD  = skidQ;
    unique case (stateQ)
      SB_EMPTY: begin
        if (accept) begin
          stateD = SB_ONE;
          mainD  = data_i;
        end
      end
      SB_ONE: begin
        if (accept && deliver) begin
          mainD = data_i;
        end else if (accept) begin
          skidD  = data_i;
          stateD = SB_FULL;
        end else if (deliver) begin
          stateD = SB_EMPTY;
        end
      end
      SB_FULL: begin
        if (deliver) begin
          mainD  = skidQ;
          stateD = SB_ONE;
        end
      end
      default: stateD = SB_EMPTY;
    endcase
    // Flush wins over any handshake seen in the same cycle.
    if (flush_i) stateD = SB_EMPTY;
    readyD = (stateD != SB_FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ <= SB_EMPTY;
      readyQ <= 1'b1;
      mainQ  <= '0;
      skidQ  <= '0;
    end else begin
      stateQ <= stateD;
      readyQ <= readyD;
      mainQ  <= mainD;
      skidQ  <= skidD;
    end
  end

  assign ready_o     = readyQ;
  assign valid_o     = (stateQ != SB_EMPTY);
  assign data_o      = mainQ;
  assign mainValid_o = (stateQ != SB_EMPTY);
  assign skidValid_o = (stateQ == SB_FULL);

endmodule

// File: rtl/du_ex_skid_reg_way0.sv
// Way0 decode->execute pipeline register: packs the decoded fields into a
// bundle, buffers it in a two-entry skid buffer and reports occupancy.
module du_ex_skid_reg_way0
  import b8_pkg::*;
#(
  parameter int XLEN_P    = XLEN,
  parameter int IADDR_W_P = IADDR_W,
  parameter int PID_W_P   = PID_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [4:0]           rdAddr_i,
  input  logic                 rdWriteEnable_i,
  input  logic [IADDR_W_P-1:0] instAddr_i,
  input  logic [XLEN_P-1:0]    rs1ReadData_i,
  input  logic [XLEN_P-1:0]    rs2ReadData_i,
  input  logic [XLEN_P-1:0]    imm_i,
  input  logic [6:0]           opCode_i,
  input  logic [2:0]           funct3_i,
  input  logic [6:0]           funct7_i,
  input  logic [5:0]           shamt_i,
  input  logic [PID_W_P-1:0]   pID_i,
  output logic [4:0]           rdAddr_o,
  output logic                 rdWriteEnable_o,
  output logic [IADDR_W_P-1:0] instAddr_o,
  output logic [XLEN_P-1:0]    rs1ReadData_o,
  output logic [XLEN_P-1:0]    rs2ReadData_o,
  output logic [XLEN_P-1:0]    imm_o,
  output logic [6:0]           opCode_o,
  output logic [2:0]           funct3_o,
  output logic [6:0]           funct7_o,
  output logic [5:0]           shamt_o,
  output logic [PID_W_P-1:0]   pID_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [1:0]           occupancy_o
);

  du_bundle_t inBundle, outBundle;
  logic       mainValid, skidValid;

  assign inBundle = '{
    rdAddr:        rdAddr_i,
    rdWriteEnable: rdWriteEnable_i,
    instAddr:      instAddr_i,
    rs1ReadData:   rs1ReadData_i,
    rs2ReadData:   rs2ReadData_i,
    imm:           imm_i,
    opCode:        opCode_i,
    funct3:        funct3_i,
    funct7:        funct7_i,
    shamt:         shamt_i,
    pID:           pID_i
  };

  skid_buffer #(.T(du_bundle_t)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_i      (inBundle),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (outBundle),
    .mainValid_o (mainValid),
    .skidValid_o (skidValid)
  );

  assign rdAddr_o        = outBundle.rdAddr;
  assign rdWriteEnable_o = outBundle.rdWriteEnable;
  assign instAddr_o      = outBundle.instAddr;
  assign rs1ReadData_o   = outBundle.rs1ReadData;
  assign rs2ReadData_o   = outBundle.rs2ReadData;
  assign imm_o           = outBundle.imm;
  assign opCode_o        = outBundle.opCode;
  assign funct3_o        = outBundle.funct3;
  assign funct7_o        = outBundle.funct7;
  assign shamt_o         = outBundle.shamt;
  assign pID_o           = outBundle.pID;

  // Both valid bits are flops, so this sum changes only with the state.
  assign occupancy_o = {1'b0, mainValid} + {1'b0, skidValid};

  apSkidImpliesMain: assert property (@(posedge clk) disable iff (!rst)
    skidValid |-> mainValid);
  apNotReadyFull: assert property (@(posedge clk) disable iff (!rst)
    !ready_o |-> (occupancy_o == 2'd2));

endmodule

// File: tb/tb_du_ex_skid_reg_way0.sv
// Directed, table-driven bench for the way0 decode->execute skid register.
module tb_du_ex_skid_reg_way0;
  import b8_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, flush_i, valid_i, ready_o, ready_i, valid_o;
  logic [1:0]        occupancy_o;
  logic [4:0]        rdAddr_i, rdAddr_o;
  logic              rdWriteEnable_i, rdWriteEnable_o;
  logic [IADDR_W-1:0] instAddr_i, instAddr_o;
  logic [XLEN-1:0]   rs1ReadData_i, rs1ReadData_o, rs2ReadData_i, rs2ReadData_o;
  logic [XLEN-1:0]   imm_i, imm_o;
  logic [6:0]        opCode_i, opCode_o, funct7_i, funct7_o;
  logic [2:0]        funct3_i, funct3_o;
  logic [5:0]        shamt_i, shamt_o;
  logic [PID_W-1:0]  pID_i, pID_o;

  int checks = 0;
  int errors = 0;

  du_ex_skid_reg_way0 dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .rdAddr_i(rdAddr_i), .rdWriteEnable_i(rdWriteEnable_i), .instAddr_i(instAddr_i),
    .rs1ReadData_i(rs1ReadData_i), .rs2ReadData_i(rs2ReadData_i), .imm_i(imm_i),
    .opCode_i(opCode_i), .funct3_i(funct3_i), .funct7_i(funct7_i), .shamt_i(shamt_i),
    .pID_i(pID_i),
    .rdAddr_o(rdAddr_o), .rdWriteEnable_o(rdWriteEnable_o), .instAddr_o(instAddr_o),
    .rs1ReadData_o(rs1ReadData_o), .rs2ReadData_o(rs2ReadData_o), .imm_o(imm_o),
    .opCode_o(opCode_o), .funct3_o(funct3_o), .funct7_o(funct7_o), .shamt_o(shamt_o),
    .pID_o(pID_o),
    .valid_o(valid_o), .ready_i(ready_i), .occupancy_o(occupancy_o)
  );

  typedef struct {
    logic       flush;
    logic       valid;
    int         tag;
    logic       readyIn;
    logic       expValid;
    logic       expReady;
    logic [1:0] expOcc;
    int         expTag;
  } vec_t;

  vec_t vecs[$];

  // Every bundle is a pure function of its tag, so the expected payload is rebuilt here.
  function automatic du_bundle_t mkBundle(input int tag);
    du_bundle_t b;
    logic [7:0] t;
    t = tag[7:0];
    b.rdAddr        = t[4:0];
    b.rdWriteEnable = t[0];
    b.instAddr      = 32'h8000_0000 + 32'(tag) * 32'd4;
    b.rs1ReadData   = {16{t[3:0]}};
    b.rs2ReadData   = {8{t}} ^ 64'hA5A5_5A5A_C3C3_3C3C;
    b.imm           = (tag == 22) ? 64'hFFFF_FFFF_FFFF_F800 : {56'h0, t};
    b.opCode        = t[0] ? OPC_OP_IMM : OPC_OP;
    b.funct3        = t[2:0];
    b.funct7        = t[7:1];
    b.shamt         = t[5:0];
    b.pID           = t[1:0];
    return b;
  endfunction

  function automatic du_bundle_t gotBundle();
    du_bundle_t b;
    b.rdAddr = rdAddr_o;           b.rdWriteEnable = rdWriteEnable_o;
    b.instAddr = instAddr_o;       b.rs1ReadData = rs1ReadData_o;
    b.rs2ReadData = rs2ReadData_o; b.imm = imm_o;
    b.opCode = opCode_o;           b.funct3 = funct3_o;
    b.funct7 = funct7_o;           b.shamt = shamt_o;
    b.pID = pID_o;
    return b;
  endfunction

  task automatic driveBundle(input int tag);
    du_bundle_t b;
    b = mkBundle(tag);
    rdAddr_i = b.rdAddr;           rdWriteEnable_i = b.rdWriteEnable;
    instAddr_i = b.instAddr;       rs1ReadData_i = b.rs1ReadData;
    rs2ReadData_i = b.rs2ReadData; imm_i = b.imm;
    opCode_i = b.opCode;           funct3_i = b.funct3;
    funct7_i = b.funct7;           shamt_i = b.shamt;
    pID_i = b.pID;
  endtask

  task automatic checkBit(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic expValid, input logic expReady,
                             input logic [1:0] expOcc, input int expTag, input logic expZero);
    du_bundle_t exp;
    du_bundle_t got;
    checkBit({name, " valid_o"}, 64'(valid_o), 64'(expValid));
    checkBit({name, " ready_o"}, 64'(ready_o), 64'(expReady));
    checkBit({name, " occupancy_o"}, 64'(occupancy_o), 64'(expOcc));
    if (expValid || expZero) begin
      exp = expZero ? '0 : mkBundle(expTag);
      got = gotBundle();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL %s payload: got %h, expected %h", name, got, exp);
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    flush_i = v.flush;
    valid_i = v.valid;
    ready_i = v.readyIn;
    driveBundle(v.tag);
    @(posedge clk);
    #1;
  endtask

  task automatic runVectors(input string group);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("%s[%0d]", group, i), vecs[i].expValid, vecs[i].expReady,
                  vecs[i].expOcc, vecs[i].expTag, 1'b0);
    end
    vecs.delete();
  endtask

  initial begin
    // Reset with a valid bundle presented: nothing may be captured.
    rst = 1'b0; flush_i = 1'b0; valid_i = 1'b1; ready_i = 1'b1;
    driveBundle(5);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 1'b0, 1'b1, 2'd0, 0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    valid_i = 1'b0;

    // flush, valid, tag, readyIn, expValid, expReady, expOcc, expTag
    for (int n = 1; n <= 8; n++)
      vecs.push_back('{1'b0, 1'b1, n, 1'b1, 1'b1, 1'b1, 2'd1, n});
    vecs.push_back('{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 2'd0, 0});
    runVectors("stream");

    vecs.push_back('{1'b0, 1'b1, 10, 1'b0, 1'b1, 1'b1, 2'd1, 10});
    vecs.push_back('{1'b0, 1'b1, 11, 1'b0, 1'b1, 1'b0, 2'd2, 10});
    vecs.push_back('{1'b0, 1'b1, 12, 1'b0, 1'b1, 1'b0, 2'd2, 10});
    vecs.push_back('{1'b0, 1'b1, 12, 1'b1, 1'b1, 1'b1, 2'd1, 11});
    vecs.push_back('{1'b0, 1'b1, 12, 1'b1, 1'b1, 1'b1, 2'd1, 12});
    vecs.push_back('{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 2'd0, 0});
    runVectors("backpressure");

    vecs.push_back('{1'b0, 1'b1, 20, 1'b0, 1'b1, 1'b1, 2'd1, 20});
    vecs.push_back('{1'b0, 1'b1, 21, 1'b0, 1'b1, 1'b0, 2'd2, 20});
    vecs.push_back('{1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 2'd0, 0});
    vecs.push_back('{1'b0, 1'b1, 22, 1'b1, 1'b1, 1'b1, 2'd1, 22});
    vecs.push_back('{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 2'd0, 0});
    runVectors("flushFull");

    vecs.push_back('{1'b0, 1'b1, 8'h31, 1'b1, 1'b1, 1'b1, 2'd1, 8'h31});
    vecs.push_back('{1'b0, 1'b1, 8'h32, 1'b1, 1'b1, 1'b1, 2'd1, 8'h32});
    vecs.push_back('{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 2'd0, 0});
    runVectors("acceptDeliver");

    // Flush in ONE while both handshakes fire: the new bundle must be dropped.
    vecs.push_back('{1'b0, 1'b1, 50, 1'b0, 1'b1, 1'b1, 2'd1, 50});
    vecs.push_back('{1'b1, 1'b1, 51, 1'b1, 1'b0, 1'b1, 2'd0, 0});
    vecs.push_back('{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 2'd0, 0});
    runVectors("flushOne");

    // Async reset asserted between edges while FULL.
    vecs.push_back('{1'b0, 1'b1, 40, 1'b0, 1'b1, 1'b1, 2'd1, 40});
    vecs.push_back('{1'b0, 1'b1, 41, 1'b0, 1'b1, 1'b0, 2'd2, 40});
    runVectors("preReset");
    #2;
    rst = 1'b0;
    #1;
    checkOutput("asyncReset", 1'b0, 1'b1, 2'd0, 0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    valid_i = 1'b0;
    vecs.push_back('{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 2'd0, 0});
    vecs.push_back('{1'b0, 1'b1, 42, 1'b1, 1'b1, 1'b1, 2'd1, 42});
    vecs.push_back('{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 2'd0, 0});
    runVectors("postReset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
